// File: rtl/mant_div_pkg.sv
// mant_div_pkg: shared state encoding and default sizes for the iterative mantissa divider.
package mant_div_pkg;
  localparam int WIDTH_DEF = 24;
  localparam int FRAC_DEF = 24;
  localparam int CNT_W = $clog2(WIDTH_DEF + FRAC_DEF);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/mant_div_iter_if.sv
// mant_div_iter_if: operand-in / quotient-out stream between the FP divide stage and the divider.
import mant_div_pkg::*;
interface mant_div_iter_if #(parameter int WIDTH = WIDTH_DEF, parameter int FRAC_W = FRAC_DEF);
  logic s_valid;
  logic s_ready;
  logic [WIDTH-1:0] s_dividend;
  logic [WIDTH-1:0] s_divisor;
  logic m_valid;
  logic m_ready;
  logic [WIDTH+FRAC_W-1:0] m_quot;
  logic m_sticky;
  logic m_dbz;
  modport master(output s_valid, s_dividend, s_divisor, m_ready, input s_ready, m_valid, m_quot, m_sticky, m_dbz);
  modport slave(input s_valid, s_dividend, s_divisor, m_ready, output s_ready, m_valid, m_quot, m_sticky, m_dbz);
endinterface

// File: rtl/mant_div_step.sv
// mant_div_step: one combinational restoring-division iteration.
import mant_div_pkg::*;
module mant_div_step #(parameter int WIDTH = WIDTH_DEF) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dsr,
  input  logic             in_bit,
  output logic [WIDTH:0]   rem_nxt,
  output logic             q_bit
);
  logic [WIDTH+1:0] sh;
  logic [WIDTH:0]   trial;
  always_comb begin
    sh = {rem, in_bit};
    q_bit = sh >= {2'b0, dsr};
    trial = sh[WIDTH:0] - {1'b0, dsr};
    rem_nxt = q_bit ? trial : sh[WIDTH:0];
  end
endmodule

// File: rtl/mant_div_iter.sv
// mant_div_iter: radix-2 restoring mantissa divider, one op in flight; MANT_DIV_STICKY_EN enables m_sticky.
import mant_div_pkg::*;
module mant_div_iter #(parameter int WIDTH = WIDTH_DEF, parameter int FRAC_W = FRAC_DEF) (
  input logic clk,
  input logic rst,
  mant_div_iter_if.slave bus
);
  localparam int QW = WIDTH + FRAC_W;
  localparam int CW = (CNT_W > $clog2(QW)) ? CNT_W : $clog2(QW);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, rem_nxt;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic sticky_q, sticky_d, dbz_q, dbz_d, q_bit;
  mant_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem_q), .dsr(dsr_q), .in_bit(dvd_q[QW-1]), .rem_nxt(rem_nxt), .q_bit(q_bit)
  );
  // quotient bits shift into the vacated LSBs of the working dividend
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    dvd_d = dvd_q;
    sticky_d = sticky_q;
    dbz_d = dbz_q;
    if (state_q == IDLE && bus.s_valid) begin
      dbz_d = bus.s_divisor == '0;
      dsr_d = bus.s_divisor;
      rem_d = '0;
      sticky_d = 1'b0;
      cnt_d = dbz_d ? '0 : CW'(QW - 1);
      dvd_d = dbz_d ? '1 : {bus.s_dividend, {FRAC_W{1'b0}}};
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      if (!dbz_q) begin
        rem_d = rem_nxt;
        dvd_d = {dvd_q[QW-2:0], q_bit};
`ifdef MANT_DIV_STICKY_EN
        sticky_d = |rem_nxt;
`endif
      end
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? DONE : BUSY;
    end else if (state_q == DONE && bus.m_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      dvd_q <= '0;
      sticky_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      dvd_q <= dvd_d;
      sticky_q <= sticky_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.s_ready = state_q == IDLE && !rst;
  assign bus.m_valid = state_q == DONE;
  assign bus.m_quot = dvd_q;
  assign bus.m_sticky = sticky_q;
  assign bus.m_dbz = dbz_q;
endmodule

// File: tb/tb_mant_div_iter.sv
// tb_mant_div_iter: randomized self-checking bench against an arithmetic quotient/remainder model.
module tb_mant_div_iter;
  localparam int W = 24;
  localparam int F = 24;
  localparam int QW = W + F;
`ifdef MANT_DIV_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mant_div_iter_if #(.WIDTH(W), .FRAC_W(F)) bus();
  mant_div_iter #(.WIDTH(W), .FRAC_W(F)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [QW-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned n = 64'(a) << F;
    return b == 0 ? {QW{1'b1}} : QW'(n / 64'(b));
  endfunction

  function automatic logic ref_sticky(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned n = 64'(a) << F;
    return b != 0 && STK && (n % 64'(b)) != 0;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [QW-1:0] q, output logic s, output logic z, output int lat);
    int n = 0;
    while (!bus.s_ready && n < 100) begin tick(); n++; end
    bus.s_valid = 1'b1;
    bus.s_dividend = a;
    bus.s_divisor = b;
    tick();
    bus.s_valid = 1'b0;
    bus.s_dividend = W'($urandom);
    bus.s_divisor = W'($urandom);
    lat = 0;
    while (!bus.m_valid && lat < 200) begin tick(); lat++; end
    q = bus.m_quot;
    s = bus.m_sticky;
    z = bus.m_dbz;
    repeat (hold) tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.m_quot !== '0) begin errors++; $display("FAIL reset_m_quot got=%h exp=0", bus.m_quot); end
    checks++; if ({bus.m_sticky, bus.m_dbz} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.m_sticky, bus.m_dbz}); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_known;
    logic [QW-1:0] q; logic s, z; int lat;
    run_op(24'hC00000, 24'h800000, 0, q, s, z, lat);
    checks++; if (q !== 48'h000001800000) begin errors++; $display("FAIL q_1p5_1p0 got=%h exp=000001800000", q); end
    checks++; if ({s, z} !== 2'b00) begin errors++; $display("FAIL flags_1p5_1p0 got=%b exp=00", {s, z}); end
    checks++; if (lat !== 48) begin errors++; $display("FAIL lat_1p5_1p0 got=%0d exp=48", lat); end
    run_op(24'h800000, 24'hC00000, 1, q, s, z, lat);
    checks++; if (q !== 48'h000000AAAAAA) begin errors++; $display("FAIL q_1p0_1p5 got=%h exp=000000aaaaaa", q); end
    checks++; if (s !== STK) begin errors++; $display("FAIL sticky_1p0_1p5 got=%b exp=%b", s, STK); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL dbz_1p0_1p5 got=%b exp=0", z); end
  endtask

  task automatic test_dbz;
    logic [QW-1:0] q; logic s, z; int lat;
    run_op(24'h900000, 24'h000000, 2, q, s, z, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_lat got=%0d exp=1", lat); end
    checks++; if (q !== {QW{1'b1}}) begin errors++; $display("FAIL dbz_quot got=%h exp=ffffffffffff", q); end
    checks++; if ({s, z} !== 2'b01) begin errors++; $display("FAIL dbz_flags got=%b exp=01", {s, z}); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    while (!bus.s_ready && n < 100) begin tick(); n++; end
    bus.s_valid = 1'b1;
    bus.s_dividend = 24'hC00000;
    bus.s_divisor = 24'h800000;
    tick();
    bus.s_valid = 1'b0;
    n = 0;
    while (!bus.m_valid && n < 200) begin tick(); n++; end
    checks++; if (n !== 48) begin errors++; $display("FAIL bp_lat got=%0d exp=48", n); end
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_dividend = W'({1'b1, 23'($urandom)});
      bus.s_divisor = W'({1'b1, 23'($urandom)});
      tick();
      checks++; if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ctrl cyc=%0d got v=%b r=%b exp v=1 r=0", i, bus.m_valid, bus.s_ready); end
      checks++; if (bus.m_quot !== 48'h000001800000 || bus.m_dbz !== 1'b0 || bus.m_sticky !== 1'b0) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h/%b%b exp=000001800000/00", i, bus.m_quot, bus.m_sticky, bus.m_dbz); end
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", bus.m_valid, bus.s_ready); end
    repeat (3) tick();
    checks++; if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_op got r=%b v=%b exp r=1 v=0", bus.s_ready, bus.m_valid); end
  endtask

  task automatic test_reset_mid_op;
    logic [QW-1:0] q; logic s, z; int lat; int stale = 0;
    logic [W-1:0] a, b;
    bus.s_valid = 1'b1;
    bus.s_dividend = 24'h800000;
    bus.s_divisor = 24'hC00000;
    tick();
    bus.s_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b r=%b exp v=0 r=0", bus.m_valid, bus.s_ready); end
    checks++; if (bus.m_quot !== '0) begin errors++; $display("FAIL rst_mid_quot got=%h exp=0", bus.m_quot); end
    rst = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus.s_ready); end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.m_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
    a = W'({1'b1, 23'($urandom)});
    b = W'({1'b1, 23'($urandom)});
    run_op(a, b, 0, q, s, z, lat);
    checks++; if (q !== ref_quot(a, b) || s !== ref_sticky(a, b)) begin errors++; $display("FAIL rst_recover got=%h/%b exp=%h/%b", q, s, ref_quot(a, b), ref_sticky(a, b)); end
  endtask

  task automatic test_back_to_back;
    logic [QW-1:0] q; logic s, z; int lat;
    logic [W-1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = W'({1'b1, 23'($urandom)});
      b = W'({1'b1, 23'($urandom)});
      run_op(a, b, int'($urandom_range(0, 3)), q, s, z, lat);
      checks++; if (q !== ref_quot(a, b)) begin errors++; $display("FAIL b2b_quot i=%0d a=%h b=%h got=%h exp=%h", i, a, b, q, ref_quot(a, b)); end
      checks++; if (s !== ref_sticky(a, b)) begin errors++; $display("FAIL b2b_sticky i=%0d got=%b exp=%b", i, s, ref_sticky(a, b)); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL b2b_dbz i=%0d got=%b exp=0", i, z); end
      checks++; if (lat !== 48) begin errors++; $display("FAIL b2b_lat i=%0d got=%0d exp=48", i, lat); end
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_dividend = '0;
    bus.s_divisor = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_known();
    test_dbz();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
